// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// State encoding, memRW encoding and default bus widths.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_DONE
  } arb_state_e;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/arb_priority_picker.sv
// Combinational rotating-start priority picker.
// Ports: req_i, start_i (first index searched) -> win_oh_o, win_idx_o.
module arb_priority_picker #(
  parameter int N_REQ = 2,
  parameter int OW    = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [OW-1:0]    start_i,
  output logic [N_REQ-1:0] win_oh_o,
  output logic [OW-1:0]    win_idx_o
);

  int   pos;
  logic found;

  always_comb begin
    win_oh_o  = '0;
    win_idx_o = '0;
    found     = 1'b0;
    pos       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      pos = (int'(start_i) + i) % N_REQ;
      if (!found && req_i[pos]) begin
        found          = 1'b1;
        win_oh_o[pos]  = 1'b1;
        win_idx_o      = OW'(pos);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between N_REQ requesters (0 = control unit).
// Ports: req/lock/rw/addr/wdata in, gnt/done/rdata/busy/owner out,
// mem_* towards memory. State moves on negedge CLK.
// Build option: ARB_ROUND_ROBIN_EN selects rotating priority,
// otherwise lowest index wins.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int  N_REQ      = 2,
  parameter int  ADDR_W     = DEF_ADDR_W,
  parameter int  DATA_W     = DEF_DATA_W,
  parameter int  ACCESS_CYC = 1,
  parameter int  MAX_BURST  = 4,
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        lock,
  input  logic [N_REQ-1:0]        rw,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  input  logic [N_REQ*DATA_W-1:0] wdata,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        done,
  output logic [DATA_W-1:0]       rdata,
  output logic                    busy,
  output logic [OW-1:0]           owner,
  output logic                    mem_en,
  output logic                    mem_rw,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata
);

  localparam int CW = (ACCESS_CYC > 1) ? $clog2(ACCESS_CYC) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_INIT  = CW'(ACCESS_CYC - 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  arb_state_e        state_q;
  logic [N_REQ-1:0]  gnt_q;
  logic [N_REQ-1:0]  done_q;
  logic [DATA_W-1:0] rdata_q;
  logic [OW-1:0]     owner_q;
  logic              mem_en_q;
  logic              mem_rw_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [CW-1:0]     cnt_q;
  logic [BW-1:0]     burst_q;

  logic [ADDR_W-1:0] addr_a  [N_REQ];
  logic [DATA_W-1:0] wdata_a [N_REQ];
  logic [N_REQ-1:0]  win_oh;
  logic [OW-1:0]     win_idx;
  logic [OW-1:0]     start;
  logic [OW-1:0]     sel;
  logic              any;
  logic              cont;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_a[g]  = addr[g*ADDR_W +: ADDR_W];
    assign wdata_a[g] = wdata[g*DATA_W +: DATA_W];
  end

  assign any = |req;

  // New grants latch from the picker, burst continuations from the owner.
  assign sel  = (state_q == ARB_IDLE) ? win_idx : owner_q;
  assign cont = req[owner_q] && lock[owner_q] && (burst_q < BURST_MAX);

  arb_priority_picker #(
    .N_REQ (N_REQ),
    .OW    (OW)
  ) u_pick (
    .req_i     (req),
    .start_i   (start),
    .win_oh_o  (win_oh),
    .win_idx_o (win_idx)
  );

`ifdef ARB_ROUND_ROBIN_EN
  logic [OW-1:0] ptr_q;

  // Holds the index just after the last winner.
  always_ff @(negedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr_q <= '0;
    end else if (state_q == ARB_IDLE && any) begin
      ptr_q <= (win_idx == OW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  assign start = ptr_q;
`else
  assign start = '0;
`endif

  always_ff @(negedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ARB_IDLE;
      gnt_q       <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      owner_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cnt_q       <= '0;
      burst_q     <= '0;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (any) begin
            gnt_q       <= win_oh;
            owner_q     <= win_idx;
            mem_en_q    <= 1'b1;
            mem_rw_q    <= rw[sel];
            mem_addr_q  <= addr_a[sel];
            mem_wdata_q <= wdata_a[sel];
            cnt_q       <= CNT_INIT;
            burst_q     <= BW'(1);
            state_q     <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            if (mem_rw_q == MEM_READ) begin
              rdata_q <= mem_rdata;
            end
            done_q   <= gnt_q;
            mem_en_q <= 1'b0;
            state_q  <= ARB_DONE;
          end
        end
        ARB_DONE: begin
          done_q <= '0;
          if (cont) begin
            mem_en_q    <= 1'b1;
            mem_rw_q    <= rw[sel];
            mem_addr_q  <= addr_a[sel];
            mem_wdata_q <= wdata_a[sel];
            cnt_q       <= CNT_INIT;
            burst_q     <= burst_q + 1'b1;
            state_q     <= ARB_ACCESS;
          end else begin
            gnt_q   <= '0;
            state_q <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign busy      = (state_q != ARB_IDLE);
  assign owner     = owner_q;
  assign mem_en    = mem_en_q;
  assign mem_rw    = mem_rw_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (2 requesters, 2-cycle access).
// Requester agents feed transactions; a monitor checks every access.
module tb_mem_port_arbiter;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int AC = 2;
  localparam int MB = 4;

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic [31:0] EXP_ALT   = 32'h01010101;
  localparam logic [31:0] EXP_BURST = 32'h0222102;
`else
  localparam logic [31:0] EXP_ALT   = 32'h00001111;
  localparam logic [31:0] EXP_BURST = 32'h0222021;
`endif

  logic          CLK = 1'b1;
  logic          RST_N = 1'b0;
  logic [1:0]    req = '0;
  logic [1:0]    lock = '0;
  logic [1:0]    rw = '0;
  logic [2*AW-1:0] addr = '0;
  logic [2*DW-1:0] wdata = '0;
  logic [1:0]    gnt;
  logic [1:0]    done;
  logic [DW-1:0] rdata;
  logic          busy;
  logic [0:0]    owner;
  logic          mem_en;
  logic          mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  mem_port_arbiter #(
    .N_REQ      (2),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .ACCESS_CYC (AC),
    .MAX_BURST  (MB)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .req       (req),
    .lock      (lock),
    .rw        (rw),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .done      (done),
    .rdata     (rdata),
    .busy      (busy),
    .owner     (owner),
    .mem_en    (mem_en),
    .mem_rw    (mem_rw),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial forever #5 CLK = ~CLK;

  typedef struct {
    logic          rw;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          lk;
    int            gap;
  } tx_t;

  tx_t prog [2][$];
  tx_t exp_q[2][$];
  int  glog[$];
  int  gapc[2];
  logic active[2];

  logic [DW-1:0] tbmem [32];
  logic [DW-1:0] refmem[32];
  logic [DW-1:0] exp_rdata;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk_eq(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    $display("FAIL %s: got event missing want event", nm);
  endtask

  // Memory device: combinational read, write on each strobed cycle.
  always_comb mem_rdata = tbmem[mem_addr];

  always @(negedge CLK) begin
    if (mem_en && mem_rw) tbmem[mem_addr] <= mem_wdata;
  end

  task automatic push(input int i, input logic r, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic lk, input int gp);
    tx_t t;
    t.rw = r; t.a = a; t.d = d; t.lk = lk; t.gap = gp;
    prog[i].push_back(t);
  endtask

  task automatic load(input int i);
    tx_t t;
    t = prog[i].pop_front();
    req[i]  = 1'b1;
    rw[i]   = t.rw;
    lock[i] = t.lk;
    addr[i*AW +: AW]  = t.a;
    wdata[i*DW +: DW] = t.d;
    exp_q[i].push_back(t);
    active[i] = 1'b1;
  endtask

  // Requester agents: hold req until done, chain the next transaction
  // in the done cycle or drop req.
  always @(posedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      if (!RST_N) begin
        prog[i].delete();
        req[i] = 1'b0;
        lock[i] = 1'b0;
        active[i] = 1'b0;
        gapc[i] = 0;
      end else if (active[i]) begin
        if (done[i]) begin
          if (prog[i].size() > 0 && prog[i][0].gap == 0) load(i);
          else begin
            req[i] = 1'b0;
            lock[i] = 1'b0;
            active[i] = 1'b0;
          end
        end
      end else if (prog[i].size() > 0) begin
        if (gapc[i] < prog[i][0].gap) gapc[i]++;
        else begin
          gapc[i] = 0;
          load(i);
        end
      end
    end
  end

  // Monitor / scoreboard.
  logic prev_en = 1'b0;
  logic prev_busy = 1'b0;
  int   en_cnt = 0;
  int   run = 0;

  always @(posedge CLK) begin
    int  w;
    tx_t t;
    if (!RST_N) begin
      prev_en = 1'b0;
      prev_busy = 1'b0;
      en_cnt = 0;
      run = 0;
      exp_rdata = '0;
      exp_q[0].delete();
      exp_q[1].delete();
    end else begin
      if (mem_en) begin
        if (!prev_en) begin
          w = gnt[1] ? 1 : 0;
          chk_eq("acc_gnt", 32'(gnt), 32'(1 << w));
          chk_eq("acc_owner", 32'(owner), 32'(w));
          if (exp_q[w].size() == 0) fail_now("acc_unexpected");
          else begin
            t = exp_q[w][0];
            chk_eq("acc_addr", 32'(mem_addr), 32'(t.a));
            chk_eq("acc_rw", 32'(mem_rw), 32'(t.rw));
            if (t.rw) chk_eq("acc_wdata", 32'(mem_wdata), 32'(t.d));
          end
          glog.push_back(w + (prev_busy ? 2 : 0));
          run = prev_busy ? run + 1 : 1;
          chk_eq("burst_limit", 32'(run <= MB), 32'd1);
          en_cnt = 0;
        end
        en_cnt++;
      end
      if (|done) begin
        w = done[1] ? 1 : 0;
        chk_eq("done_onehot", 32'(done), 32'(1 << w));
        chk_eq("done_gnt", 32'(gnt[w]), 32'd1);
        chk_eq("access_len", 32'(en_cnt), 32'(AC));
        if (exp_q[w].size() == 0) fail_now("done_unexpected");
        else begin
          t = exp_q[w].pop_front();
          if (!t.rw) exp_rdata = refmem[t.a];
          else refmem[t.a] = t.d;
          chk_eq("rdata", 32'(rdata), 32'(exp_rdata));
        end
      end
      prev_en = mem_en;
      prev_busy = busy;
    end
  end

  function automatic logic [31:0] enc_log();
    logic [31:0] v;
    v = '0;
    foreach (glog[k]) v = (v << 4) | 32'(glog[k]);
    return v;
  endfunction

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while ((prog[0].size() > 0 || prog[1].size() > 0 ||
            active[0] || active[1] || busy) && n < lim) begin
      @(posedge CLK); #2;
      n++;
    end
    if (n >= lim) fail_now("idle_timeout");
  endtask

  initial begin
    int lat;
    int bad;
    logic [DW-1:0] v;
    for (int i = 0; i < 32; i++) begin
      v = DW'($urandom);
      tbmem[i] = v;
      refmem[i] = v;
    end

    // Reset values
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    chk_eq("rst_gnt", 32'(gnt), 32'd0);
    chk_eq("rst_done", 32'(done), 32'd0);
    chk_eq("rst_rdata", 32'(rdata), 32'd0);
    chk_eq("rst_busy", 32'(busy), 32'd0);
    chk_eq("rst_owner", 32'(owner), 32'd0);
    chk_eq("rst_mem_en", 32'(mem_en), 32'd0);
    chk_eq("rst_mem_rw", 32'(mem_rw), 32'd0);
    chk_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk_eq("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    RST_N = 1'b1;
    @(posedge CLK); #2;

    // Single read with latency
    tbmem[3] = 8'hA5;
    refmem[3] = 8'hA5;
    push(0, 1'b0, 5'h03, 8'h00, 1'b0, 0);
    @(posedge CLK);
    @(negedge CLK); #1;
    chk_eq("rd_gnt", 32'(gnt), 32'h1);
    chk_eq("rd_addr", 32'(mem_addr), 32'h03);
    chk_eq("rd_en", 32'(mem_en), 32'd1);
    lat = 1;
    while (!done[0] && lat < 20) begin
      @(negedge CLK); #1;
      lat++;
    end
    chk_eq("rd_latency", 32'(lat), 32'(AC + 1));
    chk_eq("rd_value", 32'(rdata), 32'hA5);
    wait_idle(200);

    // Write from requester 1
    push(1, 1'b1, 5'h1F, 8'h3C, 1'b0, 0);
    wait_idle(200);
    chk_eq("wr_mem", 32'(tbmem[31]), 32'h3C);
    chk_eq("wr_rdata_kept", 32'(rdata), 32'hA5);

    // Simultaneous requests
    glog.delete();
    push(0, 1'b0, 5'h05, 8'h00, 1'b0, 0);
    push(1, 1'b0, 5'h06, 8'h00, 1'b0, 0);
    wait_idle(200);
    chk_eq("prio_len", 32'(glog.size()), 32'd2);
    chk_eq("prio_order", enc_log(), 32'h01);

    // Both held, no lock
    glog.delete();
    for (int k = 0; k < 4; k++) begin
      push(0, 1'b0, 5'(k), 8'h00, 1'b0, 0);
      push(1, 1'b1, 5'(k + 8), 8'(k + 8'h50), 1'b0, 0);
    end
    wait_idle(400);
    chk_eq("alt_len", 32'(glog.size()), 32'd8);
    chk_eq("alt_order", enc_log(), EXP_ALT);

    // Locked burst past the limit with requester 1 waiting
    glog.delete();
    for (int k = 0; k < 6; k++) push(0, 1'b1, 5'(k + 16), 8'(k + 8'hC0), 1'b1, 0);
    push(1, 1'b0, 5'h10, 8'h00, 1'b0, 0);
    wait_idle(400);
    chk_eq("burst_len", 32'(glog.size()), 32'd7);
    chk_eq("burst_order", enc_log(), EXP_BURST);

    // Reset during an access
    push(0, 1'b0, 5'h07, 8'h00, 1'b0, 0);
    lat = 0;
    @(negedge CLK); #1;
    while (!mem_en && lat < 20) begin
      @(negedge CLK); #1;
      lat++;
    end
    if (lat >= 20) fail_now("rst_mid_start");
    #2 RST_N = 1'b0;
    #1;
    chk_eq("rst_mid_gnt", 32'(gnt), 32'd0);
    chk_eq("rst_mid_en", 32'(mem_en), 32'd0);
    chk_eq("rst_mid_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge CLK);
    #2 RST_N = 1'b1;
    @(posedge CLK); #2;
    chk_eq("rst_rel_busy", 32'(busy), 32'd0);
    chk_eq("rst_rel_rdata", 32'(rdata), 32'd0);

    // Random traffic
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 40; k++) begin
        push(i, 1'($urandom), 5'($urandom_range(7, 0)), DW'($urandom),
             1'($urandom), ($urandom_range(3, 0) == 0) ? $urandom_range(2, 0) : 0);
      end
    end
    wait_idle(5000);
    chk_eq("drain_q0", 32'(exp_q[0].size()), 32'd0);
    chk_eq("drain_q1", 32'(exp_q[1].size()), 32'd0);
    bad = 0;
    for (int i = 0; i < 32; i++) if (tbmem[i] !== refmem[i]) bad++;
    chk_eq("mem_image", 32'(bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
